pipeline_sequencer: RTL
=======================

// Module: pipeline_sequencer
// PURPOSE
//   Central stall/flush sequencer for the 5-stage pipeline (IF_ID, ID_EX, EX_MEM, MEM_WB).
//   Detects load-use hazards, branch-taken flushes and multi-cycle data-memory waits.
//   Drives the per-stage write-enable, flush and bubble controls plus the PC write enable.
//   Holds the pipeline idle until start_i, and halts with a sticky error on a memory timeout.
// PARAMETERS
//   MEM_TIMEOUT  16  max consecutive MEMWAIT cycles before HALT (>=1)
//   CNT_W        32  width of performance counters (PIPE_SEQ_PERF_EN only)
// PORTS
//   clk_i            in   1      clock; all state updates on rising edge
//   rst_i            in   1      reset, synchronous, active-high
//   start_i          in   1      level; sampled only in IDLE
//   id_rs_i          in   5      rs field of the instruction in ID
//   id_rt_i          in   5      rt field of the instruction in ID
//   id_uses_rt_i     in   1      ID instruction reads rt as a source
//   ex_memread_i     in   1      instruction in EX is a load
//   ex_rt_i          in   5      destination (rt) of the load in EX
//   branch_taken_i   in   1      branch resolved taken in ID this cycle
//   mem_req_i        in   1      MEM stage holds a load/store
//   mem_ready_i      in   1      data memory completes the access this cycle
//   pc_write_o       out  1      PC register load enable
//   if_id_write_o    out  1      IF_ID load enable
//   if_id_flush_o    out  1      IF_ID clear to NOP
//   id_ex_write_o    out  1      ID_EX load enable
//   id_ex_bubble_o   out  1      ID_EX loads NOP (control fields zero)
//   ex_mem_write_o   out  1      EX_MEM load enable
//   mem_wb_bubble_o  out  1      MEM_WB loads NOP
//   run_o            out  1      1 in RUN or MEMWAIT
//   err_o            out  1      sticky memory-timeout flag
//   state_o          out  2      IDLE=0, RUN=1, MEMWAIT=2, HALT=3
//   stall_cnt_o      out  CNT_W  cycles with pc_write_o=0 while run_o=1 (PIPE_SEQ_PERF_EN only)
//   flush_cnt_o      out  CNT_W  cycles with if_id_flush_o=1 (PIPE_SEQ_PERF_EN only)
// BEHAVIOUR
//   - Reset (rst_i=1 at an edge): state=IDLE; timer, err_o and counters cleared.
//     In IDLE every enable, flush and bubble output is 0, and run_o=0.
//   - IDLE: start_i=1 -> RUN at the next edge. start_i is ignored in all other states.
//   - Control outputs are combinational from state and inputs, so they act in the same cycle.
//   - Priority in RUN: memory wait > load-use > branch flush > normal.
//   - Normal: all write enables 1; flush and bubble outputs 0.
//   - Memory wait (mem_req_i & ~mem_ready_i):
//       pc/if_id/id_ex/ex_mem write = 0; mem_wb_bubble_o = 1.
//       Next state MEMWAIT; timer is loaded with 1.
//   - Load-use: ex_memread_i & ex_rt_i!=0 & (ex_rt_i==id_rs_i | (id_uses_rt_i & ex_rt_i==id_rt_i)).
//       pc/if_id write = 0; id_ex_bubble_o = 1; ex_mem write = 1.
//       If branch_taken_i is also high, it is ignored this cycle and re-evaluated after the stall.
//   - Branch: if_id_flush_o = 1; pc_write_o = 1. Exactly one cycle per taken branch.
//   - MEMWAIT:
//       mem_ready_i=0 -> same freeze as memory wait; timer increments.
//         If the timer reaches MEM_TIMEOUT -> HALT and err_o=1.
//       mem_ready_i=1 -> outputs evaluated as in RUN (load-use and branch apply); next state RUN.
//   - HALT: all outputs as IDLE except err_o=1. Only rst_i exits HALT.
//   - Timer saturates at MEM_TIMEOUT. Counters wrap modulo 2^CNT_W.
// CONFIGURATION
//   PIPE_SEQ_PERF_EN defined: stall_cnt_o and flush_cnt_o exist and count as specified above.
//   Not defined: both ports are absent and no counter flops are built.
// STRUCTURE
//   pipe_seq_pkg: state typedef (IDLE/RUN/MEMWAIT/HALT), STATE_W=2, REG_ZERO=5'd0.
//   Sub-module mem_wait_timer: load/increment/saturate counter with a timeout flag.
//     Its width is $clog2(MEM_TIMEOUT+1).
// TESTING
//   1. Reset, then start_i=1 for 1 cycle -> state_o 0 then 1; all enables 1 in RUN.
//   2. ex_memread_i=1, ex_rt_i=8, id_rs_i=8 -> pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1 for 1 cycle.
//      Repeat with ex_rt_i=0 -> no stall.
//   3. branch_taken_i=1 together with the step-2 load-use -> cycle 1 stall only.
//      Cycle 2 (hazard gone) -> if_id_flush_o=1.
//   4. mem_req_i=1, mem_ready_i=0 for 3 cycles then 1 -> 3 frozen cycles with mem_wb_bubble_o=1.
//      The 4th cycle advances; state returns to RUN.
//   5. MEM_TIMEOUT=4, mem_ready_i held 0 -> HALT, err_o=1.
//      start_i is ignored; rst_i clears err_o and returns to IDLE.
//   6. PIPE_SEQ_PERF_EN: after tests 2-4 -> stall_cnt_o=5 (1+1+3); flush_cnt_o=1.
//      rst_i asserted mid-MEMWAIT -> IDLE, counters 0.

Source files
------------

// File: rtl/pipe_seq_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_seq_pkg;

  localparam int unsigned STATE_W = 2;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  typedef enum logic [STATE_W-1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StMemWait = 2'd2,
    StHalt    = 2'd3
  } state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Consecutive memory-wait cycle timer: load to 1, increment, saturate at MaxCount.
// timeout_o fires on the increment that brings the count up to MaxCount.
module mem_wait_timer #(
  parameter int unsigned MaxCount = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic inc_i,
  output logic timeout_o
);

  localparam int unsigned W = $clog2(MaxCount + 1);
  localparam logic [W-1:0] MaxVal  = W'(MaxCount);
  localparam logic [W-1:0] LastVal = W'(MaxCount - 1);

  logic [W-1:0] count_q;

  // Count register; load wins over increment, increment stops at MaxVal.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= W'(1);
    end else if (inc_i && (count_q != MaxVal)) begin
      count_q <= count_q + W'(1);
    end
  end

  // Timeout when this increment makes (or keeps) the count at MaxVal.
  always_comb begin
    timeout_o = inc_i && (count_q >= LastVal);
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Optional performance counters are built only when PIPE_SEQ_PERF_EN is defined.
module pipeline_sequencer
  import pipe_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
`ifdef PIPE_SEQ_PERF_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [4:0]         id_rs_i,
  input  logic [4:0]         id_rt_i,
  input  logic               id_uses_rt_i,
  input  logic               ex_memread_i,
  input  logic [4:0]         ex_rt_i,
  input  logic               branch_taken_i,
  input  logic               mem_req_i,
  input  logic               mem_ready_i,
  output logic               pc_write_o,
  output logic               if_id_write_o,
  output logic               if_id_flush_o,
  output logic               id_ex_write_o,
  output logic               id_ex_bubble_o,
  output logic               ex_mem_write_o,
  output logic               mem_wb_bubble_o,
  output logic               run_o,
  output logic               err_o,
  output logic [STATE_W-1:0] state_o
`ifdef PIPE_SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   flush_cnt_o
`endif
);

  state_e state_q;
  logic   err_q;
  logic   frozen;   // whole front of the pipe held, MEM_WB gets a bubble
  logic   active;   // hazard/branch/normal controls apply this cycle
  logic   load_use;
  logic   timeout;

  mem_wait_timer #(
    .MaxCount (MEM_TIMEOUT)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (frozen && (state_q == StRun)),
    .inc_i     (frozen && (state_q == StMemWait)),
    .timeout_o (timeout)
  );

  // Hazard detection and per-stage control decode; priority wait > load-use > branch.
  always_comb begin
    load_use = ex_memread_i && (ex_rt_i != REG_ZERO) &&
               ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
    frozen          = 1'b0;
    active          = 1'b0;
    pc_write_o      = 1'b0;
    if_id_write_o   = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_write_o   = 1'b0;
    id_ex_bubble_o  = 1'b0;
    ex_mem_write_o  = 1'b0;
    mem_wb_bubble_o = 1'b0;
    case (state_q)
      StRun: begin
        active = 1'b1;
        frozen = mem_req_i && !mem_ready_i;
      end
      StMemWait: begin
        active = mem_ready_i;
        frozen = !mem_ready_i;
      end
      default: ;
    endcase
    if (frozen) begin
      mem_wb_bubble_o = 1'b1;
    end else if (active) begin
      if (load_use) begin
        // Stall IF/ID; a simultaneous branch is picked up once the hazard clears.
        id_ex_write_o  = 1'b1;
        id_ex_bubble_o = 1'b1;
        ex_mem_write_o = 1'b1;
      end else begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        id_ex_write_o  = 1'b1;
        ex_mem_write_o = 1'b1;
        if_id_flush_o  = branch_taken_i;
      end
    end
  end

  // Sequencer FSM with sticky timeout error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle:    if (start_i) state_q <= StRun;
        StRun:     if (frozen) state_q <= StMemWait;
        StMemWait: begin
          if (mem_ready_i) begin
            state_q <= StRun;
          end else if (timeout) begin
            state_q <= StHalt;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    run_o   = (state_q == StRun) || (state_q == StMemWait);
    err_o   = err_q;
    state_o = state_q;
  end

`ifdef PIPE_SEQ_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Performance counters: stalled running cycles and IF_ID flushes, wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (run_o && !pc_write_o) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (if_id_flush_o)        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
